// File: rtl/fios_result_reduce.sv
// fios_result_reduce
//
// Collects the word-serial Montgomery product T (LSW first, T < 2p) from the
// cascaded FIOS multiplier. It then applies the final conditional subtraction
// T - p one word per cycle and presents the reduced s-word result in parallel
// behind a valid/ready handshake.
//
// Ports:
//   clock_i         system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   res_valid_i     res_i carries a result word this cycle
//   res_i           multiplier result word, LSW first
//   p_i             modulus, stable from first result word until result accepted
//   result_ready_i  downstream accepts result_o
//   busy_o          collecting words or subtracting
//   result_valid_o  result_o valid, held until accepted
//   result_o        reduced result (T mod p)
//   overflow_o      sticky: a result word arrived when it could not be accepted

module fios_result_reduce #(
    parameter int unsigned s      = 8,
    parameter int unsigned WORD_W = 17
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  res_valid_i,
    input  logic [WORD_W-1:0]     res_i,
    input  logic [s*WORD_W-1:0]   p_i,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  result_valid_o,
    output logic [s*WORD_W-1:0]   result_o,
    output logic                  overflow_o
);

    localparam int unsigned CNT_W = (s > 1) ? $clog2(s) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(s - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StSub, StOut} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           wcnt_q, wcnt_d;
    logic [CNT_W-1:0]           k_q, k_d;
    logic                       borrow_q, borrow_d;
    logic [s-1:0][WORD_W-1:0]   t_q, t_d;
    logic [s-1:0][WORD_W-1:0]   d_q, d_d;
    logic [s*WORD_W-1:0]        result_q, result_d;
    logic                       valid_q, valid_d;
    logic                       overflow_q, overflow_d;

    logic [s-1:0][WORD_W-1:0]   p_words;
    logic [WORD_W:0]            sub_diff;
    logic [s-1:0][WORD_W-1:0]   d_final;

    assign p_words = p_i;

    // One word of the ripple subtraction; the MSB of sub_diff is the borrow out.
    assign sub_diff = {1'b0, t_q[k_q]} - {1'b0, p_words[k_q]} - (WORD_W+1)'(borrow_q);

    // D as it will stand after this cycle's word is written, used on the last word
    // so the result mux sees the freshly computed top word.
    always_comb begin
        d_final       = d_q;
        d_final[k_q]  = sub_diff[WORD_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        k_d        = k_q;
        borrow_d   = borrow_q;
        t_d        = t_q;
        d_d        = d_q;
        result_d   = result_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (res_valid_i) begin
                    t_d[0]   = res_i;
                    k_d      = '0;
                    borrow_d = 1'b0;
                    if (s == 1) begin
                        state_d = StSub;
                    end else begin
                        wcnt_d  = CNT_W'(1);
                        state_d = StCollect;
                    end
                end
            end

            StCollect: begin
                if (res_valid_i) begin
                    t_d[wcnt_q] = res_i;
                    if (wcnt_q == LAST) begin
                        wcnt_d   = '0;
                        k_d      = '0;
                        borrow_d = 1'b0;
                        state_d  = StSub;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end

            StSub: begin
                if (res_valid_i) begin
                    overflow_d = 1'b1;
                end
                d_d[k_q] = sub_diff[WORD_W-1:0];
                borrow_d = sub_diff[WORD_W];
                if (k_q == LAST) begin
                    // No final borrow means T >= p, so the difference is the answer.
                    result_d = sub_diff[WORD_W] ? t_q : d_final;
                    valid_d  = 1'b1;
                    k_d      = '0;
                    state_d  = StOut;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end

            StOut: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    // A word arriving on the handshake cycle starts the next product.
                    if (res_valid_i) begin
                        t_d[0]   = res_i;
                        k_d      = '0;
                        borrow_d = 1'b0;
                        if (s == 1) begin
                            state_d = StSub;
                        end else begin
                            wcnt_d  = CNT_W'(1);
                            state_d = StCollect;
                        end
                    end
                end else if (res_valid_i) begin
                    overflow_d = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            k_q        <= '0;
            borrow_q   <= 1'b0;
            t_q        <= '0;
            d_q        <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            k_q        <= k_d;
            borrow_q   <= borrow_d;
            t_q        <= t_d;
            d_q        <= d_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy_o         = (state_q == StCollect) || (state_q == StSub);
    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fios_result_reduce.sv
// Testbench for fios_result_reduce with s=2, WORD_W=17. Expected results are
// queued when a product is sent; a monitor pops and compares on each handshake.

module tb_fios_result_reduce;

    localparam int unsigned S = 2;
    localparam int unsigned W = 17;

    logic               clock_i;
    logic               reset_i;
    logic               res_valid_i;
    logic [W-1:0]       res_i;
    logic [S*W-1:0]     p_i;
    logic               result_ready_i;
    logic               busy_o;
    logic               result_valid_o;
    logic [S*W-1:0]     result_o;
    logic               overflow_o;

    int n_checks;
    int n_fails;
    logic [S*W-1:0] exp_q[$];

    fios_result_reduce #(
        .s      (S),
        .WORD_W (W)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .res_valid_i    (res_valid_i),
        .res_i          (res_i),
        .p_i            (p_i),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .overflow_o     (overflow_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the presented result at every handshake.
    always @(negedge clock_i) begin
        if (!reset_i && result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(result_o), 64'hDEAD);
            end else begin
                check("result", 64'(result_o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        res_valid_i = 1'b1;
        res_i       = w;
        tick();
        res_valid_i = 1'b0;
        res_i       = '0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!result_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!result_valid_o) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((result_valid_o || busy_o) && n < 20) begin
            tick();
            n++;
        end
        if (result_valid_o || busy_o) check({name, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic product(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [S*W-1:0] exp);
        exp_q.push_back(exp);
        send_word(w0);
        send_word(w1);
        wait_valid("product");
        wait_idle("product");
    endtask

    logic [S*W-1:0] held;

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        res_valid_i    = 1'b0;
        res_i          = '0;
        p_i            = '0;
        result_ready_i = 1'b1;
        reset_i        = 1'b1;
        #12;
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_valid", 64'(result_valid_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_overflow", 64'(overflow_o), 64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        tick();

        // T=7, p=5, with explicit latency check: valid rises 2 edges after last word.
        p_i = {17'h00000, 17'h00005};
        exp_q.push_back(34'h2);
        send_word(17'h00007);
        send_word(17'h00000);
        check("lat_edge0_valid", 64'(result_valid_o), 64'd0);
        check("lat_busy_sub", 64'(busy_o), 64'd1);
        tick();
        check("lat_edge1_valid", 64'(result_valid_o), 64'd0);
        tick();
        check("lat_edge2_valid", 64'(result_valid_o), 64'd1);
        check("lat_edge2_busy", 64'(busy_o), 64'd0);
        wait_idle("t7");
        check("overflow_clean", 64'(overflow_o), 64'd0);

        product(17'h00003, 17'h00000, 34'h3);   // borrow path keeps T
        product(17'h00005, 17'h00000, 34'h0);   // equality

        p_i = {17'h00001, 17'h00001};
        product(17'h1FFFF, 17'h00001, {17'h00000, 17'h1FFFE});
        product(17'h00000, 17'h00001, {17'h00001, 17'h00000});  // borrow ripples

        // Gapped stream.
        p_i = {17'h00000, 17'h00005};
        exp_q.push_back(34'h2);
        send_word(17'h00007);
        for (int i = 0; i < 3; i++) begin
            check("gap_busy", 64'(busy_o), 64'd1);
            tick();
        end
        send_word(17'h00000);
        wait_valid("gap");
        wait_idle("gap");

        // Back-pressure with a stray word during OUT.
        result_ready_i = 1'b0;
        exp_q.push_back(34'h2);
        send_word(17'h00007);
        send_word(17'h00000);
        wait_valid("bp");
        held = result_o;
        check("bp_held_value", 64'(held), 64'h2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                send_word(17'h00009);
            end else begin
                tick();
            end
            check("bp_result_stable", 64'(result_o), 64'(held));
            check("bp_valid_held", 64'(result_valid_o), 64'd1);
        end
        check("bp_overflow_set", 64'(overflow_o), 64'd1);
        result_ready_i = 1'b1;
        tick();
        check("bp_back_idle_valid", 64'(result_valid_o), 64'd0);
        check("bp_back_idle_busy", 64'(busy_o), 64'd0);
        check("bp_overflow_sticky", 64'(overflow_o), 64'd1);

        // Reset during SUB with k=1.
        send_word(17'h00007);
        send_word(17'h00000);
        tick();
        reset_i = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_valid", 64'(result_valid_o), 64'd0);
        check("rst_mid_overflow", 64'(overflow_o), 64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        tick();
        check("rst_after_valid", 64'(result_valid_o), 64'd0);
        product(17'h00007, 17'h00000, 34'h2);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
